// File: rtl/objscan.sv
// objscan: rectangular object hit scanner for a VGA pixel stream.
// Each object has shadow registers (written at any time) and active registers
// (loaded from the shadows on frame_start). Per-pixel hits, a lowest-index
// priority encode, and per-frame collision capture are produced from the
// active set.
module objscan #(
  parameter int NOBJ = 4,
  parameter int CW   = 10,
  parameter int SZW  = 6,
  parameter int SELW = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [CW-1:0]   screenx,
  input  logic [CW-1:0]   screeny,
  input  logic            video_active,
  input  logic            frame_start,
  input  logic            wr_en,
  input  logic [SELW-1:0] wr_sel,
  input  logic [CW-1:0]   wr_x,
  input  logic [CW-1:0]   wr_y,
  input  logic [SZW-1:0]  wr_w,
  input  logic [SZW-1:0]  wr_h,
  input  logic            wr_vis,
  output logic [NOBJ-1:0] obj_scan,
  output logic            pri_valid,
  output logic [SELW-1:0] pri_idx,
  output logic [NOBJ-1:0] coll,
  output logic            coll_irq
);

  // Shadow object registers (CPU-side copy)
  logic [CW-1:0]   sx_q   [NOBJ];
  logic [CW-1:0]   sy_q   [NOBJ];
  logic [SZW-1:0]  sw_q   [NOBJ];
  logic [SZW-1:0]  sh_q   [NOBJ];
  logic [NOBJ-1:0] svis_q;
  logic [CW-1:0]   sx_d   [NOBJ];
  logic [CW-1:0]   sy_d   [NOBJ];
  logic [SZW-1:0]  sw_d   [NOBJ];
  logic [SZW-1:0]  sh_d   [NOBJ];
  logic [NOBJ-1:0] svis_d;

  // Active object registers (used by the scanner)
  logic [CW-1:0]   ax_q   [NOBJ];
  logic [CW-1:0]   ay_q   [NOBJ];
  logic [SZW-1:0]  aw_q   [NOBJ];
  logic [SZW-1:0]  ah_q   [NOBJ];
  logic [NOBJ-1:0] avis_q;
  logic [CW-1:0]   ax_d   [NOBJ];
  logic [CW-1:0]   ay_d   [NOBJ];
  logic [SZW-1:0]  aw_d   [NOBJ];
  logic [SZW-1:0]  ah_d   [NOBJ];
  logic [NOBJ-1:0] avis_d;

  // Scan / priority / collision state
  logic [NOBJ-1:0] hit;
  logic [NOBJ-1:0] coll_term;
  logic [NOBJ-1:0] obj_scan_q, obj_scan_d;
  logic            pri_valid_q, pri_valid_d;
  logic [SELW-1:0] pri_idx_q, pri_idx_d;
  logic [NOBJ-1:0] coll_live_q, coll_live_d;
  logic [NOBJ-1:0] coll_q, coll_d;
  logic            coll_irq_q, coll_irq_d;

  // Shadow write and frame_start shadow-to-active transfer with write-through.
  // An index outside 0..NOBJ-1 never matches any object, so it is ignored.
  always_comb begin
    svis_d = svis_q;
    avis_d = avis_q;
    for (int i = 0; i < NOBJ; i++) begin
      sx_d[i] = sx_q[i];
      sy_d[i] = sy_q[i];
      sw_d[i] = sw_q[i];
      sh_d[i] = sh_q[i];
      ax_d[i] = ax_q[i];
      ay_d[i] = ay_q[i];
      aw_d[i] = aw_q[i];
      ah_d[i] = ah_q[i];
      if (wr_en && (wr_sel == SELW'(i))) begin
        sx_d[i]   = wr_x;
        sy_d[i]   = wr_y;
        sw_d[i]   = wr_w;
        sh_d[i]   = wr_h;
        svis_d[i] = wr_vis;
      end
      if (frame_start) begin
        ax_d[i]   = sx_d[i];
        ay_d[i]   = sy_d[i];
        aw_d[i]   = sw_d[i];
        ah_d[i]   = sh_d[i];
        avis_d[i] = svis_d[i];
      end
    end
  end

  // Per-object rectangle test; end coordinates are formed one bit wider so an
  // object running past the right/bottom edge is clipped instead of wrapping.
  for (genvar gi = 0; gi < NOBJ; gi++) begin : g_hit
    logic [CW:0] x_end;
    logic [CW:0] y_end;
    logic        in_x;
    logic        in_y;
    assign x_end = {1'b0, ax_q[gi]} + {{(CW + 1 - SZW){1'b0}}, aw_q[gi]};
    assign y_end = {1'b0, ay_q[gi]} + {{(CW + 1 - SZW){1'b0}}, ah_q[gi]};
    assign in_x  = (screenx >= ax_q[gi]) && ({1'b0, screenx} < x_end);
    assign in_y  = (screeny >= ay_q[gi]) && ({1'b0, screeny} < y_end);
    assign hit[gi] = avis_q[gi] & video_active & (aw_q[gi] != '0) &
                     (ah_q[gi] != '0) & in_x & in_y;
  end

  // Collision term: object i hits together with at least one other object
  always_comb begin
    coll_term = '0;
    for (int i = 0; i < NOBJ; i++) begin
      for (int j = 0; j < NOBJ; j++) begin
        if ((i != j) && hit[i] && hit[j]) begin
          coll_term[i] = 1'b1;
        end
      end
    end
  end

  // Priority encode (lowest index wins) and frame collision capture
  always_comb begin
    obj_scan_d  = hit;
    pri_valid_d = |hit;
    pri_idx_d   = '0;
    for (int i = NOBJ - 1; i >= 0; i--) begin
      if (hit[i]) begin
        pri_idx_d = SELW'(i);
      end
    end
    coll_d      = coll_q;
    coll_live_d = coll_live_q | coll_term;
    coll_irq_d  = 1'b0;
    if (frame_start) begin
      coll_d      = coll_live_q | coll_term;
      coll_live_d = '0;
      coll_irq_d  = |(coll_live_q | coll_term);
    end
  end

  // Object register file flops; reset makes every object invisible
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      svis_q <= '0;
      avis_q <= '0;
      for (int i = 0; i < NOBJ; i++) begin
        sx_q[i] <= '0;
        sy_q[i] <= '0;
        sw_q[i] <= '0;
        sh_q[i] <= '0;
        ax_q[i] <= '0;
        ay_q[i] <= '0;
        aw_q[i] <= '0;
        ah_q[i] <= '0;
      end
    end else begin
      svis_q <= svis_d;
      avis_q <= avis_d;
      for (int i = 0; i < NOBJ; i++) begin
        sx_q[i] <= sx_d[i];
        sy_q[i] <= sy_d[i];
        sw_q[i] <= sw_d[i];
        sh_q[i] <= sh_d[i];
        ax_q[i] <= ax_d[i];
        ay_q[i] <= ay_d[i];
        aw_q[i] <= aw_d[i];
        ah_q[i] <= ah_d[i];
      end
    end
  end

  // Output and collision flops
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      obj_scan_q  <= '0;
      pri_valid_q <= 1'b0;
      pri_idx_q   <= '0;
      coll_live_q <= '0;
      coll_q      <= '0;
      coll_irq_q  <= 1'b0;
    end else begin
      obj_scan_q  <= obj_scan_d;
      pri_valid_q <= pri_valid_d;
      pri_idx_q   <= pri_idx_d;
      coll_live_q <= coll_live_d;
      coll_q      <= coll_d;
      coll_irq_q  <= coll_irq_d;
    end
  end

  assign obj_scan  = obj_scan_q;
  assign pri_valid = pri_valid_q;
  assign pri_idx   = pri_idx_q;
  assign coll      = coll_q;
  assign coll_irq  = coll_irq_q;

endmodule
